// File: rtl/music_beat_sequencer.sv
// Beat sequencer for the score ROMs: steps the 1/4-beat index at a fixed tempo,
// handles play/pause/stop, song select, looping, and muxes the selected tone out.
module music_beat_sequencer #(
   parameter int          CLK_HZ    = 100_000_000,
   parameter int          BEAT_HZ   = 8,
   parameter int          LAST_BEAT = 255,
   parameter int          NUM_SONGS = 4,
   parameter logic [31:0] SILENCE   = 32'd20000,
   localparam int         SW        = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    play_pause,
   input  logic                    stop,
   input  logic                    loop_en,
   input  logic [SW-1:0]           song_sel,
   input  logic [32*NUM_SONGS-1:0] tone_in,
   output logic [7:0]              ibeat_num,
   output logic [SW-1:0]           song_idx,
   output logic [31:0]             tone_out,
   output logic                    playing,
   output logic                    beat_tick,
   output logic                    song_done
);

   localparam int DIV = CLK_HZ / BEAT_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
   localparam logic [7:0]    LAST    = 8'(LAST_BEAT);

   localparam logic [1:0] ST_STOP  = 2'd0;
   localparam logic [1:0] ST_PLAY  = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [7:0]    beat_q, beat_d;
   logic [SW-1:0] song_q, song_d;
   logic [31:0]   tone_q, tone_d;
   logic          play_q, tick_q, tick_d, done_q, done_d;
   logic          sel_ok, chg;
   logic [31:0]   tone_sel;

   // Song change request: a differing, in-range selection
   always_comb begin
      sel_ok = 32'(song_sel) < NUM_SONGS;
      chg    = sel_ok && (song_sel != song_q);
   end

   // Next-state: stop first, then song change, then play/pause and tempo stepping
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      beat_d  = beat_q;
      song_d  = song_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      if (chg) song_d = song_sel;
      if (stop) begin
         state_d = ST_STOP;
         beat_d  = '0;
         pre_d   = '0;
      end else begin
         if (chg && state_q != ST_STOP) begin
            beat_d = '0;
            pre_d  = '0;
         end
         case (state_q)
            ST_STOP: begin
               if (play_pause) begin
                  state_d = ST_PLAY;
                  pre_d   = '0;
               end
            end
            ST_PLAY: begin
               if (play_pause) begin
                  state_d = ST_PAUSE;
               end else if (!chg) begin
                  if (pre_q == PRE_MAX) begin
                     pre_d = '0;
                     if (beat_q < LAST) begin
                        beat_d = beat_q + 8'd1;
                        tick_d = 1'b1;
                     end else if (loop_en) begin
                        beat_d = '0;
                        tick_d = 1'b1;
                     end else begin
                        beat_d  = '0;
                        done_d  = 1'b1;
                        state_d = ST_STOP;
                     end
                  end else begin
                     pre_d = pre_q + 1'b1;
                  end
               end
            end
            ST_PAUSE: begin
               if (play_pause) state_d = ST_PLAY;
            end
            default: state_d = ST_STOP;
         endcase
      end
   end

   // Select the loaded song's tone; silence whenever the next state is not PLAY
   always_comb begin
      tone_sel = SILENCE;
      for (int k = 0; k < NUM_SONGS; k++) begin
         if (32'(song_q) == k) tone_sel = tone_in[32*k +: 32];
      end
      tone_d = (state_d == ST_PLAY) ? tone_sel : SILENCE;
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_STOP;
         pre_q   <= '0;
         beat_q  <= '0;
         song_q  <= '0;
         tone_q  <= SILENCE;
         play_q  <= 1'b0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         beat_q  <= beat_d;
         song_q  <= song_d;
         tone_q  <= tone_d;
         play_q  <= (state_d == ST_PLAY);
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

   assign ibeat_num = beat_q;
   assign song_idx  = song_q;
   assign tone_out  = tone_q;
   assign playing   = play_q;
   assign beat_tick = tick_q;
   assign song_done = done_q;

endmodule

// File: tb/tb_music_beat_sequencer.sv
// Bench for music_beat_sequencer: vector table, corner sequences, random vs model.
// DIV=4, LAST_BEAT=7, two songs with tones 100+beat and 200+beat.
module tb_music_beat_sequencer;

   localparam int DIV  = 4;
   localparam int LASTB = 7;

   logic        clk = 1'b0;
   logic        rst, play_pause, stop, loop_en;
   logic [0:0]  song_sel;
   logic [63:0] tone_in;
   logic [7:0]  ibeat_num;
   logic [0:0]  song_idx;
   logic [31:0] tone_out;
   logic        playing, beat_tick, song_done;

   int total = 0;
   int bad   = 0;

   music_beat_sequencer #(
      .CLK_HZ(16), .BEAT_HZ(4), .LAST_BEAT(LASTB),
      .NUM_SONGS(2), .SILENCE(32'd20000)
   ) dut (
      .clk(clk), .rst(rst), .play_pause(play_pause), .stop(stop),
      .loop_en(loop_en), .song_sel(song_sel), .tone_in(tone_in),
      .ibeat_num(ibeat_num), .song_idx(song_idx), .tone_out(tone_out),
      .playing(playing), .beat_tick(beat_tick), .song_done(song_done)
   );

   always #5 clk = ~clk;

   always_comb tone_in = {32'd200 + 32'(ibeat_num), 32'd100 + 32'(ibeat_num)};

   typedef struct {
      logic       pp, st, lp;
      logic [0:0] sel;
      int         beat, play, tone, tick, done;
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_pp();
      play_pause = 1'b1;
      step();
      play_pause = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic do_reset();
      play_pause = 1'b0;
      stop       = 1'b0;
      loop_en    = 1'b0;
      song_sel   = 1'b0;
      rst        = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_beat"}, 32'(ibeat_num), 0);
      chk({nm, "_song"}, 32'(song_idx), 0);
      chk({nm, "_tone"}, tone_out, 20000);
      chk({nm, "_play"}, 32'(playing), 0);
      chk({nm, "_tick"}, 32'(beat_tick), 0);
      chk({nm, "_done"}, 32'(song_done), 0);
   endtask

   // random-phase reference model
   int m_mode, m_beat, m_song, m_phase;

   initial begin
      vt[0] = '{1, 0, 0, 0, 0, 1, 100, 0, 0};
      vt[1] = '{0, 0, 0, 0, 0, 1, 100, 0, 0};
      vt[2] = '{0, 0, 0, 0, 0, 1, 100, 0, 0};
      vt[3] = '{0, 0, 0, 0, 0, 1, 100, 0, 0};
      vt[4] = '{0, 0, 0, 0, 1, 1, 100, 1, 0};
      vt[5] = '{0, 0, 0, 0, 1, 1, 101, 0, 0};
      vt[6] = '{0, 0, 0, 0, 1, 1, 101, 0, 0};
      vt[7] = '{0, 0, 0, 0, 1, 1, 101, 0, 0};
      vt[8] = '{0, 0, 0, 0, 2, 1, 101, 1, 0};
      vt[9] = '{1, 1, 0, 0, 0, 0, 20000, 0, 0};

      do_reset();
      chk_reset("reset");

      for (int i = 0; i < 10; i++) begin
         play_pause = vt[i].pp;
         stop       = vt[i].st;
         loop_en    = vt[i].lp;
         song_sel   = vt[i].sel;
         step();
         chk($sformatf("vec%0d_beat", i), 32'(ibeat_num), vt[i].beat);
         chk($sformatf("vec%0d_play", i), 32'(playing), vt[i].play);
         chk($sformatf("vec%0d_tone", i), tone_out, vt[i].tone);
         chk($sformatf("vec%0d_tick", i), 32'(beat_tick), vt[i].tick);
         chk($sformatf("vec%0d_done", i), 32'(song_done), vt[i].done);
      end
      play_pause = 1'b0;
      stop       = 1'b0;

      // end of song without loop
      pulse_pp();
      repeat (28) step();
      chk("end_b7", 32'(ibeat_num), 7);
      repeat (3) step();
      chk("end_hold7", 32'(ibeat_num), 7);
      chk("end_nodone", 32'(song_done), 0);
      step();
      chk("end_beat", 32'(ibeat_num), 0);
      chk("end_done", 32'(song_done), 1);
      chk("end_tick", 32'(beat_tick), 0);
      chk("end_play", 32'(playing), 0);
      chk("end_tone", tone_out, 20000);
      step();
      chk("end_done_off", 32'(song_done), 0);

      // end of song with loop
      loop_en = 1'b1;
      pulse_pp();
      repeat (31) step();
      chk("loop_b7", 32'(ibeat_num), 7);
      step();
      chk("loop_beat", 32'(ibeat_num), 0);
      chk("loop_tick", 32'(beat_tick), 1);
      chk("loop_done", 32'(song_done), 0);
      chk("loop_play", 32'(playing), 1);
      pulse_stop();
      loop_en = 1'b0;

      // pause at beat 3 mid-prescale, resume without phase loss
      pulse_pp();
      repeat (12) step();
      chk("pause_b3", 32'(ibeat_num), 3);
      step();
      pulse_pp();
      chk("pause_play", 32'(playing), 0);
      repeat (10) step();
      chk("pause_hold", 32'(ibeat_num), 3);
      chk("pause_tone", tone_out, 20000);
      pulse_pp();
      chk("resume_play", 32'(playing), 1);
      repeat (2) step();
      chk("resume_b3", 32'(ibeat_num), 3);
      step();
      chk("resume_b4", 32'(ibeat_num), 4);
      chk("resume_tick", 32'(beat_tick), 1);
      pulse_stop();

      // song change at beat 5
      pulse_pp();
      repeat (20) step();
      chk("sel_b5", 32'(ibeat_num), 5);
      song_sel = 1'b1;
      step();
      chk("sel_beat", 32'(ibeat_num), 0);
      chk("sel_song", 32'(song_idx), 1);
      chk("sel_play", 32'(playing), 1);
      step();
      chk("sel_tone", tone_out, 200);
      pulse_stop();
      song_sel = 1'b0;
      step();
      chk("sel_stop_song", 32'(song_idx), 0);

      // asynchronous reset mid-beat at beat 6
      pulse_pp();
      repeat (24) step();
      chk("rst_b6", 32'(ibeat_num), 6);
      repeat (2) step();
      rst = 1'b1;
      #1;
      chk_reset("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // randomized run against the model
      do_reset();
      m_mode = 0; m_beat = 0; m_song = 0; m_phase = 0;
      for (int n = 0; n < 4000; n++) begin
         int  o_beat, o_song, e_tone, e_tick, e_done;
         bit  chg;
         play_pause = ($urandom_range(0, 29) == 0);
         stop       = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
         if ($urandom_range(0, 49) == 0) song_sel = ~song_sel;
         o_beat = m_beat;
         o_song = m_song;
         e_tick = 0;
         e_done = 0;
         chg = (int'(song_sel) != m_song);
         if (stop) begin
            m_mode = 0; m_beat = 0; m_phase = 0;
         end else begin
            if (chg && m_mode != 0) begin
               m_beat = 0; m_phase = 0;
            end
            if (play_pause) begin
               if (m_mode == 1) m_mode = 2;
               else begin
                  if (m_mode == 0) m_phase = 0;
                  m_mode = 1;
               end
            end else if (m_mode == 1 && !chg) begin
               m_phase++;
               if (m_phase == DIV) begin
                  m_phase = 0;
                  if (m_beat < LASTB) begin
                     m_beat++; e_tick = 1;
                  end else if (loop_en) begin
                     m_beat = 0; e_tick = 1;
                  end else begin
                     m_beat = 0; e_done = 1; m_mode = 0;
                  end
               end
            end
         end
         if (chg) m_song = int'(song_sel);
         e_tone = (m_mode == 1) ? (100 * (o_song + 1) + o_beat) : 20000;
         step();
         chk($sformatf("rnd%0d_state", n),
             {16'd0, ibeat_num, 4'd0, song_idx, playing, beat_tick, song_done},
             {16'd0, 8'(m_beat), 4'd0, 1'(m_song), m_mode == 1, 1'(e_tick), 1'(e_done)});
         chk($sformatf("rnd%0d_tone", n), tone_out, e_tone);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
